// File: rtl/tx_arbiter.sv
// Round-robin arbiter that shares one four-phase push-synchronizer transmitter
// between NUM_SRC requesters, with a completion watchdog and transfer counter.
module tx_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_grant,
  output logic                          tx_v,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_done,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic                          timeout,
  output logic                          err,
  output logic [15:0]                   xfer_count
);

  localparam int unsigned PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned WD_W  = 16;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, WAIT_READY} state_t;

  state_t                state;
  logic [PTR_W-1:0]      ptr;
  logic [WD_W-1:0]       wdog;
  logic [PTR_W-1:0]      win_idx;
  logic                  win_found;
  logic [PTR_W:0]        cand;
  logic [DATA_WIDTH-1:0] win_data;

  // First pending source at or above ptr, wrapping past NUM_SRC-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_SRC)) cand = cand - (PTR_W+1)'(NUM_SRC);
      if (!win_found && src_valid[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (win_idx == PTR_W'(i)) win_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Sequencer; grant and tx_v are raised on the arbitration edge so they sit in ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      wdog       <= '0;
      tx_v       <= 1'b0;
      tx_data    <= '0;
      src_grant  <= '0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      err        <= 1'b0;
      xfer_count <= '0;
    end else begin
      tx_v      <= 1'b0;
      src_grant <= '0;
      timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_ready && win_found) begin
            state     <= ISSUE;
            tx_data   <= win_data;
            tx_v      <= 1'b1;
            src_grant <= NUM_SRC'(1) << win_idx;
            ptr       <= (win_idx == LAST_SRC) ? '0 : win_idx + PTR_W'(1);
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT_DONE;
          wdog  <= '0;
        end
        WAIT_DONE: begin
          // Completion beats a coincident watchdog expiry.
          if (tx_done) begin
            state <= WAIT_READY;
            wdog  <= '0;
            if (xfer_count != 16'hFFFF) xfer_count <= xfer_count + 16'd1;
          end else if (wdog == WD_LAST) begin
            timeout <= 1'b1;
            err     <= 1'b1;
            wdog    <= '0;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end
        WAIT_READY: begin
          if (tx_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: expected grants/words queued at stimulus time
// and popped when tx_v is observed; transmitter behaviour modelled inline.
module tb_tx_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned NS = 4;
  localparam int unsigned TO = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NS-1:0]    src_valid = '0;
  logic [NS*DW-1:0] src_data = {8'h44, 8'hA5, 8'h22, 8'h11};
  logic [NS-1:0]    src_grant;
  logic             tx_v;
  logic [DW-1:0]    tx_data;
  logic             tx_done = 1'b0;
  logic             tx_ready = 1'b1;
  logic             busy;
  logic             timeout;
  logic             err;
  logic [15:0]      xfer_count;

  tx_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .src_valid(src_valid), .src_data(src_data),
    .src_grant(src_grant), .tx_v(tx_v), .tx_data(tx_data), .tx_done(tx_done),
    .tx_ready(tx_ready), .busy(busy), .timeout(timeout), .err(err),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NS-1:0] grant;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int idx);
    exp_t e;
    e.grant = NS'(1) << idx;
    e.data  = src_data[idx*DW +: DW];
    sb.push_back(e);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_v"},    32'(tx_v), 32'd0);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({tag, "_grant"},   32'(src_grant), 32'd0);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_err"},     32'(err), 32'd0);
    chk({tag, "_xfer"},    32'(xfer_count), 32'd0);
  endtask

  // Waits (bounded) for tx_v, then scores grant/data/busy against the queue head.
  task automatic wait_issue(input string tag, input int max_cyc);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      seen = (tx_v === 1'b1);
    end
    if (!seen) begin
      chk({tag, "_issue"}, 32'(tx_v), 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_grant"}, 32'(src_grant), 32'(e.grant));
    chk({tag, "_data"},  32'(tx_data), 32'(e.data));
    chk({tag, "_busy"},  32'(busy), 32'd1);
  endtask

  // Transmitter model: drops ready on issue, pulses done after d cycles, returns to ready.
  task automatic serve(input string tag, input int d);
    tx_ready = 1'b0;
    for (int i = 0; i < d; i++) begin
      @(negedge clk);
      chk({tag, "_no_tx_v"}, 32'(tx_v), 32'd0);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done  = 1'b0;
    tx_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single source, lane 2 carries 8'hA5
    src_valid = 4'b0100;
    push(2);
    wait_issue("single", 1);
    src_valid = '0;
    serve("single", 2);
    @(negedge clk);
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_xfer", 32'(xfer_count), 32'd1);

    // Fresh pointer, all sources pending: 0,1,2,3,0
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    src_valid = 4'b1111;
    push(0); push(1); push(2); push(3); push(0);
    for (int n = 0; n < 5; n++) begin
      wait_issue("rr", 8);
      serve("rr", 3);
    end
    src_valid = '0;
    @(negedge clk);
    chk("rr_xfer", 32'(xfer_count), 32'd5);

    // Transmitter not ready holds off the issue
    src_valid = 4'b0001;
    tx_ready  = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("notready_tx_v", 32'(tx_v), 32'd0);
      chk("notready_busy", 32'(busy), 32'd0);
    end
    tx_ready = 1'b1;
    push(0);
    wait_issue("ready_rise", 1);
    src_valid = '0;
    serve("ready_rise", 1);
    @(negedge clk);

    // Watchdog: two expiries with no done, then a late completion
    src_valid = 4'b0010;
    push(1);
    wait_issue("wd", 3);
    tx_ready  = 1'b0;
    src_valid = '0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      chk($sformatf("wd_timeout_%0d", k), 32'(timeout), 32'((k == 11) || (k == 21)));
      chk($sformatf("wd_err_%0d", k), 32'(err), 32'(k >= 11));
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done  = 1'b0;
    tx_ready = 1'b1;
    chk("wd_late_done_timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    chk("wd_done_busy", 32'(busy), 32'd0);
    chk("wd_err_sticky", 32'(err), 32'd1);
    chk("wd_xfer", 32'(xfer_count), 32'd7);

    // Done coincides with the would-be expiry: no timeout pulse
    src_valid = 4'b0100;
    push(2);
    wait_issue("tie", 3);
    tx_ready  = 1'b0;
    src_valid = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("tie_timeout_%0d", k), 32'(timeout), 32'd0);
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done  = 1'b0;
    tx_ready = 1'b1;
    chk("tie_timeout_edge", 32'(timeout), 32'd0);
    @(negedge clk);
    chk("tie_xfer", 32'(xfer_count), 32'd8);

    // Reset in WAIT_DONE, then pointer restarts at 0
    src_valid = 4'b0010;
    push(1);
    wait_issue("pre_rst", 6);
    tx_ready  = 1'b0;
    src_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    reset     = 1'b1;
    tx_ready  = 1'b1;
    src_valid = 4'b1010;
    push(1);
    wait_issue("post_rst_ptr", 3);
    src_valid = 4'b1000;
    push(3);
    serve("post_rst_ptr", 1);
    wait_issue("post_rst_src3", 6);
    src_valid = '0;
    serve("post_rst_src3", 1);
    chk("post_rst_xfer", 32'(xfer_count), 32'd2);
    @(negedge clk);

    // Saturation of the transfer counter
    force dut.xfer_count = 16'hFFFE;
    @(negedge clk);
    release dut.xfer_count;
    @(negedge clk);
    chk("sat_preload", 32'(xfer_count), 32'h0000FFFE);
    src_valid = 4'b0001;
    for (int n = 0; n < 3; n++) begin
      push(0);
      wait_issue("sat", 6);
      serve("sat", 1);
      chk($sformatf("sat_xfer_%0d", n), 32'(xfer_count), 32'h0000FFFF);
    end
    src_valid = '0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Round-robin arbiter and sequencer that shares one four-phase push-synchronizer transmitter between `NUM_SRC` local requesters. It picks one pending source and presents its word to the transmitter with a single-cycle valid. It then holds off further issues until the transmitter reports handshake completion and is back in idle. It sits between the core-side producers and the transmitter, in the transmitter's clock domain, and adds a watchdog and transfer counter for debug.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of one transmitted word.
- `NUM_SRC`, 4: number of requesters (2..8).
- `TIMEOUT`, 255: cycles allowed in WAIT_DONE before the watchdog fires (1..65535).

Ports:
- `clk`  in  1: single clock, shared with the transmitter.
- `reset`  in  1: asynchronous assert, active-low; clears all state.
- `src_valid`  in  NUM_SRC: per-source request level; must be held until granted.
- `src_data`  in  NUM_SRC*DATA_WIDTH: source i's word is in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `src_grant`  out  NUM_SRC: one-hot, one-cycle pulse; the word of that source was accepted.
- `tx_v`  out  1: one-cycle valid to the transmitter.
- `tx_data`  out  DATA_WIDTH: word to the transmitter, registered.
- `tx_done`  in  1: single-cycle completion pulse from the transmitter (synchronized ack rising edge).
- `tx_ready`  in  1: level; high while the transmitter FSM is idle.
- `busy`  out  1: high in any state other than IDLE.
- `timeout`  out  1: one-cycle pulse when the watchdog expires.
- `err`  out  1: sticky; set by `timeout`, cleared only by reset.
- `xfer_count`  out  16: completed transfers, saturating at 16'hFFFF.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, WAIT_READY.
- IDLE:
  - If `tx_ready`=1 and any `src_valid` is set, choose the winner: the first set bit searching upward from pointer `ptr`, with wrap-around.
  - Register the winner's data into `tx_data` and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle): `tx_v`=1 and `src_grant[winner]`=1, then go to WAIT_DONE. `ptr` takes (winner+1) mod NUM_SRC.
- WAIT_DONE:
  - On `tx_done`=1: increment `xfer_count` (saturating), clear the watchdog, go to WAIT_READY.
  - The watchdog counter increments every cycle in this state. When it reaches TIMEOUT without `tx_done`, pulse `timeout`, set `err`, and restart the counter. The FSM stays in WAIT_DONE; no abort.
- WAIT_READY: when `tx_ready`=1, go to IDLE.
  - `tx_ready` sampled high in the cycle of entry also counts, so the minimum dwell is 1 cycle.
- `tx_done` outside WAIT_DONE is ignored and is not counted.
- A source that drops `src_valid` before it is granted simply loses its turn. Dropping it after grant has no effect.
- `tx_data` holds its value until the next issue.

## Timing
- Reset values: state=IDLE, `ptr`=0, `tx_v`=0, `tx_data`=0, `src_grant`=0, `busy`=0, `timeout`=0, `err`=0, `xfer_count`=0, watchdog=0.
- All outputs are registered, none combinational from inputs.
- Issue latency: `src_valid` sampled high in IDLE with `tx_ready`=1 at edge N. `tx_v` and `src_grant` are high for the cycle after edge N, and `busy` is high from that cycle onward.
- Back-to-back: at least 4 cycles from one `tx_v` to the next (ISSUE, WAIT_DONE ≥1, WAIT_READY ≥1, IDLE).
- Simultaneous requests: the highest-priority source is granted. The others wait for later rounds, and each pending source is served within NUM_SRC grants.
- Pointer wrap: a grant to source NUM_SRC-1 sets `ptr`=0.
- `tx_done` and the watchdog expiry in the same cycle: `tx_done` wins and no `timeout` pulse is produced.
- Reset mid-transfer: the block returns immediately to its reset values. Any in-flight transmitter handshake is not tracked.

## Test plan
- Single source: `src_valid`=4'b0100, data 8'hA5, `tx_ready`=1 → one cycle later `tx_v`=1, `tx_data`=8'hA5, `src_grant`=4'b0100. A `tx_done` pulse then `tx_ready`=1 → IDLE, `xfer_count`=1.
- All four valid continuously, transmitter model with 3-cycle done → grant order 0,1,2,3,0. `tx_v` never asserts while `busy` is mid-transfer.
- `tx_ready`=0 with `src_valid`=4'b0001 → no `tx_v` and `busy`=0 until `tx_ready` rises. The issue follows on the next cycle.
- TIMEOUT=10, no `tx_done` → `timeout` pulses 10 cycles after WAIT_DONE entry and again 10 cycles later, and `err` stays 1. A later `tx_done` completes the transfer.
- Reset driven low during WAIT_DONE → all outputs return to their reset values. After release, `src_valid`=4'b1000 is granted with `ptr` restarted at 0.
- Force `xfer_count` to 16'hFFFE, complete 3 transfers → the count holds at 16'hFFFF.
